alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Multi-cycle unsigned multiply / divide unit that sits next to a simple
// pipeline-less core. The control unit raises Start for the current
// instruction; the unit stalls the PC while it iterates one bit per clock
// and then raises Done for exactly one cycle. Done also serves as the
// register-file write enable for Result/ResultHigh.
//
// Ports
//   Clk           single clock, all state changes on the rising edge
//   Reset         synchronous, active-high; aborts any operation
//   Start         operation request level from the control unit
//   Op            0 = unsigned multiply, 1 = unsigned divide
//   A, B          multiplicand/dividend and multiplier/divisor
//   Stall         combinational PC hold
//   Busy          high while iterating or presenting the result
//   Done          one-cycle result-valid pulse
//   Result        product low half / quotient
//   ResultHigh    product high half / remainder
//   FlagOverflow  multiply produced a nonzero high half
//   FlagDivZero   divide with a zero divisor
module alu_sequencer #(
    parameter int l = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Op,
    input  logic [l-1:0] A,
    input  logic [l-1:0] B,
    output logic         Stall,
    output logic         Busy,
    output logic         Done,
    output logic [l-1:0] Result,
    output logic [l-1:0] ResultHigh,
    output logic         FlagOverflow,
    output logic         FlagDivZero
);

    localparam int CountWidth = $clog2(l) + 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(l - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    stateT state;
    stateT nextState;

    logic [CountWidth-1:0] count;
    logic                  opIsDiv;
    logic [l-1:0]          opA;
    logic [l-1:0]          opB;

    // Shared working register pair. Multiply: workHi is the running upper
    // partial product and workLo starts as the multiplier, shifting product
    // bits in from the top. Divide: workHi is the partial remainder and
    // workLo starts as the dividend, shifting quotient bits in from the bottom.
    logic [l-1:0] workHi;
    logic [l-1:0] workLo;

    logic [l-1:0] nextHi;
    logic [l-1:0] nextLo;
    logic [l:0]   mulSum;
    logic [l:0]   divShifted;
    logic [l-1:0] divDiff;
    logic         divFits;
    logic         lastStep;

    assign lastStep = (count == LastCount);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and control outputs. Stall in IDLE follows Start
    // combinationally so the PC is held in the very cycle the request appears;
    // in DONE the PC is released so it advances together with the write.
    always_comb begin
        nextState = state;
        Stall     = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        unique case (state)
            IDLE: begin
                Stall = Start;
                if (Start) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                Stall = 1'b1;
                Busy  = 1'b1;
                if (lastStep) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // One iteration of either algorithm. The restoring divider naturally
    // yields an all-ones quotient and a remainder equal to the dividend when
    // the divisor is zero, since every trial subtraction of zero succeeds.
    // The remainder after a successful subtract is below the divisor, so the
    // low l bits of the subtraction are exact.
    always_comb begin
        mulSum     = {1'b0, workHi} + (workLo[0] ? {1'b0, opA} : '0);
        divShifted = {workHi, workLo[l-1]};
        divFits    = (divShifted >= {1'b0, opB});
        divDiff    = divShifted[l-1:0] - opB;
        nextHi     = '0;
        nextLo     = '0;
        if (opIsDiv) begin
            nextHi = divFits ? divDiff : divShifted[l-1:0];
            nextLo = {workLo[l-2:0], divFits};
        end else begin
            nextHi = mulSum[l:1];
            nextLo = {mulSum[0], workLo[l-1:1]};
        end
    end

    // Operand latch, iteration datapath and result registers. Results are
    // only written on the final iteration so partial values never reach the
    // register file outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count        <= '0;
            opIsDiv      <= 1'b0;
            opA          <= '0;
            opB          <= '0;
            workHi       <= '0;
            workLo       <= '0;
            Result       <= '0;
            ResultHigh   <= '0;
            FlagOverflow <= 1'b0;
            FlagDivZero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        opIsDiv <= Op;
                        opA     <= A;
                        opB     <= B;
                        count   <= '0;
                        workHi  <= '0;
                        workLo  <= Op ? A : B;
                    end
                end
                RUN: begin
                    workHi <= nextHi;
                    workLo <= nextLo;
                    count  <= count + CountWidth'(1);
                    if (lastStep) begin
                        Result       <= nextLo;
                        ResultHigh   <= nextHi;
                        FlagOverflow <= !opIsDiv && (nextHi != '0);
                        FlagDivZero  <= opIsDiv && (opB == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//
// Scoreboard bench for alu_sequencer. The stimulus process issues operations
// and pushes the arithmetically expected response, tagged with the cycle in
// which Done must appear; an independent monitor pops and compares whenever
// Done is seen and otherwise checks that the result registers hold steady.
module tb_alu_sequencer;

    localparam int L = 16;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Op;
    logic [L-1:0] A;
    logic [L-1:0] B;
    logic         Stall;
    logic         Busy;
    logic         Done;
    logic [L-1:0] Result;
    logic [L-1:0] ResultHigh;
    logic         FlagOverflow;
    logic         FlagDivZero;

    typedef struct {
        logic [L-1:0] result;
        logic [L-1:0] high;
        logic         ovf;
        logic         dz;
        int           doneCycle;
    } expT;

    expT expQ[$];

    int tests       = 0;
    int failures    = 0;
    int cycleCount  = 0;
    int doneCount   = 0;
    int acceptCount = 0;

    logic [L-1:0] holdResult;
    logic [L-1:0] holdHigh;
    logic         holdOvf;
    logic         holdDz;
    bit           modelValid = 1'b0;

    alu_sequencer #(.l(L)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Op           (Op),
        .A            (A),
        .B            (B),
        .Stall        (Stall),
        .Busy         (Busy),
        .Done         (Done),
        .Result       (Result),
        .ResultHigh   (ResultHigh),
        .FlagOverflow (FlagOverflow),
        .FlagDivZero  (FlagDivZero)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Plain arithmetic reference: full-width product, or quotient/remainder
    // with the defined zero-divisor answer.
    function automatic expT referenceModel(input logic op, input logic [L-1:0] a, input logic [L-1:0] b, input int acceptCycle);
        expT e;
        logic [2*L-1:0] product;
        product = {{L{1'b0}}, a} * {{L{1'b0}}, b};
        if (!op) begin
            e.result = product[L-1:0];
            e.high   = product[2*L-1:L];
            e.ovf    = (product[2*L-1:L] != '0);
            e.dz     = 1'b0;
        end else if (b == '0) begin
            e.result = '1;
            e.high   = a;
            e.ovf    = 1'b0;
            e.dz     = 1'b1;
        end else begin
            e.result = a / b;
            e.high   = a % b;
            e.ovf    = 1'b0;
            e.dz     = 1'b0;
        end
        e.doneCycle = acceptCycle + L;
        return e;
    endfunction

    // Issue one operation from IDLE, entered and left #1 after a rising edge.
    // With scramble set, Start and the operands wander randomly while the
    // unit is iterating. keepStart leaves Start high so the next call is
    // accepted back-to-back.
    task automatic applyStimulus(input logic op, input logic [L-1:0] a, input logic [L-1:0] b,
                                 input bit scramble, input bit keepStart, output int acceptCycle);
        bit runStallOk;
        bit runBusyOk;
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        @(negedge Clk);
        checkOutput("stallOnRequest", 32'(Stall), 32'd1);
        checkOutput("busyOnRequest", 32'(Busy), 32'd0);
        @(posedge Clk);
        #1;
        acceptCycle = cycleCount;
        acceptCount++;
        expQ.push_back(referenceModel(op, a, b, acceptCycle));
        runStallOk = 1'b1;
        runBusyOk  = 1'b1;
        for (int i = 0; i < L; i++) begin
            if (scramble) begin
                Start = 1'($urandom);
                Op    = 1'($urandom);
                A     = L'($urandom);
                B     = L'($urandom);
            end
            @(negedge Clk);
            if (Stall !== 1'b1) runStallOk = 1'b0;
            if (Busy !== 1'b1) runBusyOk = 1'b0;
            @(posedge Clk);
            #1;
        end
        checkOutput("stallDuringRun", 32'(runStallOk), 32'd1);
        checkOutput("busyDuringRun", 32'(runBusyOk), 32'd1);
        @(negedge Clk);
        checkOutput("stallInDone", 32'(Stall), 32'd0);
        checkOutput("busyInDone", 32'(Busy), 32'd1);
        @(posedge Clk);
        #1;
        Start = keepStart;
    endtask

    // Monitor: tracks reset, pops the scoreboard on Done, and otherwise
    // expects the result registers to hold the last delivered values.
    initial begin
        expT e;
        forever begin
            @(posedge Clk);
            cycleCount++;
            if (Reset === 1'b1) begin
                expQ.delete();
                holdResult = '0;
                holdHigh   = '0;
                holdOvf    = 1'b0;
                holdDz     = 1'b0;
                modelValid = 1'b1;
            end
            @(negedge Clk);
            if (modelValid) begin
                if (expQ.size() > 0 && expQ[0].doneCycle < cycleCount) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL doneMissing: no Done by cycle %0d, required at cycle %0d", cycleCount, expQ[0].doneCycle);
                    expQ.delete(0);
                end
                if (Done === 1'b1) begin
                    doneCount++;
                    if (expQ.size() == 0) begin
                        tests++;
                        failures++;
                        $display("[TB] FAIL unexpectedDone: Done high at cycle %0d, required no Done", cycleCount);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("doneCycle", 32'(cycleCount), 32'(e.doneCycle));
                        checkOutput("result", 32'(Result), 32'(e.result));
                        checkOutput("resultHigh", 32'(ResultHigh), 32'(e.high));
                        checkOutput("flagOverflow", 32'(FlagOverflow), 32'(e.ovf));
                        checkOutput("flagDivZero", 32'(FlagDivZero), 32'(e.dz));
                        holdResult = e.result;
                        holdHigh   = e.high;
                        holdOvf    = e.ovf;
                        holdDz     = e.dz;
                    end
                end else begin
                    checkOutput("holdResults", {Result, ResultHigh}, {holdResult, holdHigh});
                    checkOutput("holdFlags", {30'd0, FlagOverflow, FlagDivZero}, {30'd0, holdOvf, holdDz});
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycleCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus: reset behaviour, directed operations, reset abort, then a
    // randomized stream with scrambled inputs during iteration.
    initial begin
        int acc;
        int acc1;
        int acc2;
        logic [L-1:0] ra;
        logic [L-1:0] rb;
        logic         rop;
        bit           keep;

        Reset = 1'b1;
        Start = 1'b1;
        Op    = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        checkOutput("resetBusy", 32'(Busy), 32'd0);
        checkOutput("resetDone", 32'(Done), 32'd0);
        checkOutput("resetResults", {Result, ResultHigh}, 32'd0);
        checkOutput("resetFlags", {30'd0, FlagOverflow, FlagDivZero}, 32'd0);
        checkOutput("resetStallStartHigh", 32'(Stall), 32'd1);
        Start = 1'b0;
        #1;
        checkOutput("resetStallStartLow", 32'(Stall), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        applyStimulus(1'b0, 16'd7, 16'd9, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 16'h1234, 16'h0100, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 16'd100, 16'd7, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 16'd5, 16'd0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, acc);

        applyStimulus(1'b0, 16'd3, 16'd4, 1'b0, 1'b1, acc1);
        applyStimulus(1'b0, 16'd6, 16'd5, 1'b0, 1'b0, acc2);
        checkOutput("backToBackSpacing", 32'(acc2 - acc1), 32'(L + 2));

        Op    = 1'b0;
        A     = 16'h00FF;
        B     = 16'h0003;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        repeat (4) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        checkOutput("abortBusy", 32'(Busy), 32'd0);
        checkOutput("abortDone", 32'(Done), 32'd0);
        checkOutput("abortStallStartHigh", 32'(Stall), 32'd1);
        checkOutput("abortResults", {Result, ResultHigh}, 32'd0);
        Start = 1'b0;
        #1;
        checkOutput("abortStallStartLow", 32'(Stall), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (2 * L) @(posedge Clk);
        #1;

        for (int n = 0; n < 30; n++) begin
            rop = 1'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = L'($urandom_range(1, 15));
                default: rb = L'($urandom);
            endcase
            ra   = ($urandom_range(0, 3) == 0) ? L'($urandom_range(0, 255)) : L'($urandom);
            keep = 1'($urandom);
            applyStimulus(rop, ra, rb, 1'b1, keep, acc);
            if (!keep) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge Clk);
                    #1;
                end
            end
        end
        Start = 1'b0;

        for (int w = 0; w < L + 4 && expQ.size() > 0; w++) begin
            @(posedge Clk);
            #1;
        end
        checkOutput("drainQueueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("doneCountMatchesAccepts", 32'(doneCount), 32'(acceptCount));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
